// File: rtl/text_display_buffer.sv
// text_display_buffer: 80x30 character-cell text layer for the VGA console.
// Holds the character RAM behind a cursor-based write port and turns tile
// coordinates plus in-tile pixel offsets into a monochrome pixel, with the
// syncs and active flag delayed to stay aligned with that pixel.
module text_display_buffer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] char_tile_x,
    input  logic [4:0] char_tile_y,
    input  logic [2:0] pix_col,
    input  logic [3:0] pix_row,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       wr_en,
    input  logic [6:0] wr_char,
    input  logic       set_cursor,
    input  logic [6:0] cur_x_in,
    input  logic [4:0] cur_y_in,
    input  logic       clear_req,
    output logic       busy,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic       pixel_on,
    output logic       video_on_out,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        COL_LIM   = 7'(COLS);
    localparam logic [4:0]        ROW_LIM   = 5'(ROWS);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [6:0]        CH_SPACE  = 7'h20;
    localparam logic [6:0]        CH_LF     = 7'h0A;
    localparam logic [6:0]        CH_CR     = 7'h0D;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nx;
    logic [6:0]        cursor_x_nx;
    logic [4:0]        cursor_y_nx;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [6:0]        ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;

    logic [6:0] mem [0:(1<<ADDR_W)-1];

    // Stage registers of the read pipeline; video_on travels as vld_pN.
    logic [6:0] code_p0;
    logic [2:0] col_p0, col_p1;
    logic [3:0] row_p0;
    logic       vld_p0, vld_p1;
    logic       hs_p0, hs_p1;
    logic       vs_p0, vs_p1;
    logic [7:0] glyph_p1;

    // y*80 + x built from shifts so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 6) + (yw << 4) + ADDR_W'(x);
    endfunction

    // Row step with wrap from the last row back to the top.
    function automatic logic [4:0] next_row(input logic [4:0] y);
        return (y == LAST_ROW) ? 5'd0 : y + 5'd1;
    endfunction

    // Glyph set: space is blank, 'H' is drawn, every other code renders as a
    // solid identifying pattern {1, code} on all 16 rows.
    function automatic logic [7:0] font_rom(input logic [6:0] code, input logic [3:0] row);
        logic [7:0] g;
        g = {1'b1, code};
        if (code == CH_SPACE) begin
            g = 8'h00;
        end else if (code == 7'h48) begin
            case (row)
                4'd2, 4'd3, 4'd4, 4'd5, 4'd6:  g = 8'hC6;
                4'd7, 4'd8:                    g = 8'hFE;
                4'd9, 4'd10, 4'd11, 4'd12:     g = 8'hC6;
                default:                       g = 8'h00;
            endcase
        end
        return g;
    endfunction

    assign busy      = (state == CLEAR);
    assign ram_raddr = cell_addr(char_tile_x, char_tile_y);

    // Write-side state, clear address and cursor registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
            cursor_x <= cursor_x_nx;
            cursor_y <= cursor_y_nx;
        end
    end

    // Command decode: clear sweep, or one prioritized command per cycle in IDLE.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        cursor_x_nx = cursor_x;
        cursor_y_nx = cursor_y;
        ram_we      = 1'b0;
        ram_waddr   = clr_addr;
        ram_wdata   = CH_SPACE;
        if (state == CLEAR) begin
            ram_we = 1'b1;
            if (clr_addr == LAST_ADDR) begin
                state_nx    = IDLE;
                cursor_x_nx = '0;
                cursor_y_nx = '0;
            end else begin
                clr_addr_nx = clr_addr + 1'b1;
            end
        end else if (clear_req) begin
            state_nx    = CLEAR;
            clr_addr_nx = '0;
        end else if (set_cursor) begin
            if (cur_x_in < COL_LIM && cur_y_in < ROW_LIM) begin
                cursor_x_nx = cur_x_in;
                cursor_y_nx = cur_y_in;
            end
        end else if (wr_en) begin
            if (wr_char == CH_LF) begin
                cursor_x_nx = '0;
                cursor_y_nx = next_row(cursor_y);
            end else if (wr_char == CH_CR) begin
                cursor_x_nx = '0;
            end else begin
                ram_we    = 1'b1;
                ram_waddr = cell_addr(cursor_x, cursor_y);
                ram_wdata = wr_char;
                if (cursor_x == LAST_COL) begin
                    cursor_x_nx = '0;
                    cursor_y_nx = next_row(cursor_y);
                end else begin
                    cursor_x_nx = cursor_x + 7'd1;
                end
            end
        end
    end

    // Character RAM write port; the read port below sees old data on a collision.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // S1: registered RAM read, pixel offsets and sync delays.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_p0 <= '0;
            col_p0  <= '0;
            row_p0  <= '0;
            vld_p0  <= 1'b0;
            hs_p0   <= 1'b0;
            vs_p0   <= 1'b0;
        end else begin
            code_p0 <= mem[ram_raddr];
            col_p0  <= pix_col;
            row_p0  <= pix_row;
            vld_p0  <= video_on;
            hs_p0   <= hsync_in;
            vs_p0   <= vsync_in;
        end
    end

    // S2: glyph row lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glyph_p1 <= '0;
            col_p1   <= '0;
            vld_p1   <= 1'b0;
            hs_p1    <= 1'b0;
            vs_p1    <= 1'b0;
        end else begin
            glyph_p1 <= font_rom(code_p0, row_p0);
            col_p1   <= col_p0;
            vld_p1   <= vld_p0;
            hs_p1    <= hs_p0;
            vs_p1    <= vs_p0;
        end
    end

    // S3: pick the glyph bit (MSB is the leftmost pixel) and register outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_on     <= 1'b0;
            video_on_out <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            pixel_on     <= vld_p1 & glyph_p1[3'd7 - col_p1];
            video_on_out <= vld_p1;
            hsync_out    <= hs_p1;
            vsync_out    <= vs_p1;
        end
    end

endmodule

// File: tb/tb_text_display_buffer.sv
// Directed bench for text_display_buffer: clear timing, cursor commands,
// glyph readback through the pixel path and sync alignment.
module tb_text_display_buffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] char_tile_x;
    logic [4:0] char_tile_y;
    logic [2:0] pix_col;
    logic [3:0] pix_row;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       wr_en;
    logic [6:0] wr_char;
    logic       set_cursor;
    logic [6:0] cur_x_in;
    logic [4:0] cur_y_in;
    logic       clear_req;
    logic       busy;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       pixel_on;
    logic       video_on_out;
    logic       hsync_out;
    logic       vsync_out;

    int n_cmp = 0;
    int n_bad = 0;

    text_display_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .char_tile_x(char_tile_x), .char_tile_y(char_tile_y),
        .pix_col(pix_col), .pix_row(pix_row), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_char(wr_char),
        .set_cursor(set_cursor), .cur_x_in(cur_x_in), .cur_y_in(cur_y_in),
        .clear_req(clear_req), .busy(busy),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .pixel_on(pixel_on), .video_on_out(video_on_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [6:0] x, input logic [4:0] y);
        set_cursor = 1'b1; cur_x_in = x; cur_y_in = y;
        tick();
        set_cursor = 1'b0;
    endtask

    task automatic do_wr(input logic [6:0] ch);
        wr_en = 1'b1; wr_char = ch;
        tick();
        wr_en = 1'b0;
    endtask

    // Rebuild one glyph row of a cell from eight pixel_on samples.
    task automatic read_cell(input logic [6:0] x, input logic [4:0] y, input logic [3:0] r,
                             input logic vo, output logic [7:0] b);
        b = '0;
        for (int c = 0; c < 8; c++) begin
            char_tile_x = x; char_tile_y = y; pix_row = r; pix_col = 3'(c); video_on = vo;
            tick(); tick(); tick();
            b[7-c] = pixel_on;
        end
        video_on = 1'b0;
    endtask

    // Count cycles until busy drops, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 5000) begin
            tick();
            cnt++;
        end
    endtask

    logic [7:0] h_rows [16] = '{8'h00, 8'h00, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hFE,
                                8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00};

    initial begin
        int         cnt;
        logic [7:0] b;
        logic       acc;

        reset_n = 1'b0;
        char_tile_x = '0; char_tile_y = '0; pix_col = '0; pix_row = '0;
        video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        wr_en = 1'b0; wr_char = '0; set_cursor = 1'b0; cur_x_in = '0; cur_y_in = '0;
        clear_req = 1'b0;
        tick(); tick(); tick();
        check("rst_busy", busy, 1);
        check("rst_pixel", pixel_on, 0);
        check("rst_vout", video_on_out, 0);
        check("rst_hs", hsync_out, 0);
        check("rst_vs", vsync_out, 0);
        check("rst_cx", cursor_x, 0);
        check("rst_cy", cursor_y, 0);

        reset_n = 1'b1;
        wait_idle(cnt);
        check("init_clear_cycles", cnt, 2400);
        check("init_cursor", {cursor_x, cursor_y}, 0);

        // Full tile sweep with video_on high: everything is space.
        acc = 1'b0;
        video_on = 1'b1;
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 80; x++) begin
                char_tile_x = 7'(x); char_tile_y = 5'(y);
                pix_col = 3'(x); pix_row = 4'(y + x);
                tick();
                acc = acc | pixel_on;
            end
        end
        tick(); tick(); tick();
        acc = acc | pixel_on;
        video_on = 1'b0;
        check("sweep_blank", acc, 0);

        // Cursor wrap at end of row.
        do_set(7'd78, 5'd0);
        check("set_78_0", {cursor_x, cursor_y}, {7'd78, 5'd0});
        do_wr(7'h41); do_wr(7'h42); do_wr(7'h43);
        check("abc_cursor", {cursor_x, cursor_y}, {7'd1, 5'd1});
        read_cell(7'd78, 5'd0, 4'd0, 1'b1, b); check("cell_78_0", b, 8'hC1);
        read_cell(7'd79, 5'd0, 4'd5, 1'b1, b); check("cell_79_0", b, 8'hC2);
        read_cell(7'd0, 5'd1, 4'd9, 1'b1, b);  check("cell_0_1", b, 8'hC3);

        // Wrap from the last cell to the origin.
        do_set(7'd79, 5'd29);
        do_wr(7'h58);
        check("x_cursor_wrap", {cursor_x, cursor_y}, {7'd0, 5'd0});
        read_cell(7'd79, 5'd29, 4'd0, 1'b1, b); check("cell_79_29", b, 8'hD8);

        // Out-of-range cursor loads are ignored.
        do_set(7'd10, 5'd2);
        do_set(7'd80, 5'd5);
        check("set_x80_ignored", {cursor_x, cursor_y}, {7'd10, 5'd2});
        do_set(7'd3, 5'd30);
        check("set_y30_ignored", {cursor_x, cursor_y}, {7'd10, 5'd2});

        // Line feed and carriage return.
        do_set(7'd5, 5'd3);
        do_wr(7'h0A);
        check("lf_cursor", {cursor_x, cursor_y}, {7'd0, 5'd4});
        read_cell(7'd5, 5'd3, 4'd0, 1'b1, b); check("lf_no_write", b, 8'h00);
        do_set(7'd7, 5'd4);
        do_wr(7'h0D);
        check("cr_cursor", {cursor_x, cursor_y}, {7'd0, 5'd4});
        read_cell(7'd7, 5'd4, 4'd0, 1'b1, b); check("cr_no_write", b, 8'h00);

        // 'H' glyph over all 16 rows, then masked by video_on.
        do_set(7'd0, 5'd0);
        do_wr(7'h48);
        for (int r = 0; r < 16; r++) begin
            read_cell(7'd0, 5'd0, 4'(r), 1'b1, b);
            check($sformatf("h_row%0d", r), b, h_rows[r]);
        end
        read_cell(7'd0, 5'd0, 4'd7, 1'b0, b); check("h_masked", b, 8'h00);

        // Sync and video_on delay of three cycles.
        hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b1;
        tick();
        hsync_in = 1'b0; vsync_in = 1'b0; video_on = 1'b0;
        tick();
        check("sync_d2", {hsync_out, vsync_out, video_on_out}, 3'b000);
        tick();
        check("sync_d3", {hsync_out, vsync_out, video_on_out}, 3'b111);
        tick();
        check("sync_d4", {hsync_out, vsync_out, video_on_out}, 3'b000);

        // All three commands at once: only the clear acts; a second clear_req is dropped.
        do_set(7'd5, 5'd5);
        clear_req = 1'b1; set_cursor = 1'b1; cur_x_in = 7'd9; cur_y_in = 5'd9;
        wr_en = 1'b1; wr_char = 7'h5A;
        cnt = 0;
        tick(); cnt++;
        clear_req = 1'b0; set_cursor = 1'b0; wr_en = 1'b0;
        check("combo_busy", busy, 1);
        check("combo_cursor_held", {cursor_x, cursor_y}, {7'd5, 5'd5});
        while (busy && cnt < 5000) begin
            clear_req = (cnt == 100);
            tick();
            cnt++;
        end
        clear_req = 1'b0;
        check("combo_clear_cycles", cnt, 2401);
        check("combo_cursor_end", {cursor_x, cursor_y}, 0);
        read_cell(7'd5, 5'd5, 4'd0, 1'b1, b); check("combo_no_write", b, 8'h00);
        read_cell(7'd0, 5'd0, 4'd7, 1'b1, b); check("clear_erased_h", b, 8'h00);

        // Reset in the middle of a clear restarts it from address 0.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1);
        tick(); tick();
        reset_n = 1'b1;
        wait_idle(cnt);
        check("midrst_clear_cycles", cnt, 2400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_display_buffer.md
# text_display_buffer

Character-cell text display stage for the 640x480 VGA text console. It sits directly downstream of the pixel-to-tile mapping: it consumes the 80x30 tile coordinates plus the low pixel-address bits and produces a single monochrome `pixel_on` per pixel. It holds an 80x30 character buffer that the greenhouse controller writes through a cursor-based port. Sync and blanking inputs are delayed so they stay aligned with the pixel.

## Interface

Parameters:
- `COLS`, 80, characters per row.
- `ROWS`, 30, character rows.
- `ADDR_W`, 12, character RAM address width; 2400 cells are used.

Ports:
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `char_tile_x`  in  7  tile column, 0..79.
- `char_tile_y`  in  5  tile row, 0..29.
- `pix_col`  in  3  pixel column inside the tile (x[2:0]).
- `pix_row`  in  4  pixel row inside the tile (y[3:0]).
- `video_on`  in  1  active-area flag.
- `hsync_in`  in  1  horizontal sync from the sync generator.
- `vsync_in`  in  1  vertical sync from the sync generator.
- `wr_en`  in  1  write strobe, one cycle per character.
- `wr_char`  in  7  ASCII code.
- `set_cursor`  in  1  load cursor strobe.
- `cur_x_in`  in  7  cursor column to load.
- `cur_y_in`  in  5  cursor row to load.
- `clear_req`  in  1  clear-screen request strobe.
- `busy`  out  1  clear in progress; write-port commands are ignored.
- `cursor_x`  out  7  current cursor column.
- `cursor_y`  out  5  current cursor row.
- `pixel_on`  out  1  foreground pixel.
- `video_on_out`  out  1  `video_on` delayed 3 cycles.
- `hsync_out`  out  1  `hsync_in` delayed 3 cycles.
- `vsync_out`  out  1  `vsync_in` delayed 3 cycles.

## Operation

Character RAM:
- Dual-port: one write port and one registered read port.
- Cell address = y*80 + x, computed as (y<<6)+(y<<4)+x in 12 bits.
- Read-first: if a read and a write hit the same address in the same cycle, the read returns the old data.

Read pipeline (3 stages):
- S1: register the RAM read. Delay `pix_col`, `pix_row`, `video_on` and both syncs.
- S2: `font_rom` lookup at address {code, pix_row}, 1-cycle registered 8-bit output.
- S3: `pixel_on` <= `video_on`_d2 & glyph[7 - pix_col_d2]. Register the sync and `video_on` outputs in the same stage.
- Tile inputs outside 0..79 / 0..29 are don't-care, because `video_on` masks them.

Write side, FSM states IDLE and CLEAR:
- Reset enters CLEAR with clear address 0 and cursor (0,0).
- CLEAR writes 0x20 to one address per cycle, 0..2399, then goes to IDLE with cursor (0,0). The last write happens on the cycle of the transition.
- In CLEAR, `busy` = 1 and `wr_en`, `set_cursor` and `clear_req` are ignored.
- In IDLE, command priority is `clear_req` > `set_cursor` > `wr_en`; only the highest-priority command acts.
- `clear_req` in IDLE enters CLEAR at address 0.
- `set_cursor`: loads (`cur_x_in`, `cur_y_in`) if `cur_x_in` < 80 and `cur_y_in` < 30; otherwise it is ignored.
- `wr_en` with `wr_char` = 0x0A: cursor goes to (0, y+1). No RAM write.
- `wr_en` with `wr_char` = 0x0D: cursor goes to (0, y). No RAM write.
- `wr_en` with any other code: write to the cursor cell, then advance the cursor.
- Cursor advance: x+1. At x = 79, go to (0, y+1). Row 29 wraps to row 0. Cursor (79,29) advances to (0,0).

## Timing

- Read path latency is exactly 3 clocks for `pixel_on`, `video_on_out`, `hsync_out` and `vsync_out`; all four stay mutually aligned.
- The write port takes one command per cycle. The cursor update is visible on `cursor_x`/`cursor_y` the cycle after the strobe.
- A written character is visible to the read port from the cycle after the write.
- Reset values:
  - `pixel_on`, `video_on_out`, `hsync_out`, `vsync_out` = 0.
  - `cursor_x`, `cursor_y` = 0.
  - `busy` = 1 while in reset and for 2400 cycles after release. It falls the cycle after address 2399 is written.
  - All pipeline registers = 0.
- Reset asserted mid-clear: the clear restarts at address 0 on release.
- A `clear_req` that arrives during CLEAR is dropped; it is not queued.

## Test plan

- Reset release: `busy` stays 1 for 2400 clocks, then 0. Sweeping all tiles with `video_on` = 1 gives `pixel_on` = 0 throughout (space glyph).
- `set_cursor` (78,0), then write 'A','B','C': cells (78,0)='A', (79,0)='B', (0,1)='C'; cursor reads (1,1).
- `set_cursor` (79,29), write 'X': cell (79,29)='X', cursor (0,0). Separately, `set_cursor` (80,5) leaves the cursor unchanged.
- At cursor (5,3): 0x0A gives cursor (0,4) with the RAM unchanged; 0x0D at (7,4) gives (0,4).
- Write 'H' at (0,0), drive tile (0,0) over rows 0..15 and cols 0..7: `pixel_on` equals the `font_rom` bit for 'H' 3 cycles later. `video_on` = 0 forces 0. `hsync_out` and `vsync_out` lag their inputs by 3.
- IDLE with `clear_req`, `set_cursor` and `wr_en` all high in one cycle: clear runs, the write is discarded, and the cursor ends at (0,0). Pulse `reset_n` low at clear address 1000: after release, `busy` stays high for a full 2400 cycles.
